// File: rtl/tree_deserializer_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tree_deserializer_aligner                                         |
// | Brief  : 1-bit stream to FROM-bit words, sync-word frame alignment         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tree_deserializer_aligner #(
    parameter int              FROM       = 16,
    parameter int              LOGFROM    = 4,
    parameter logic [FROM-1:0] SYNC_WORD  = 16'hF628,
    parameter int              FRAME_LEN  = 8,
    parameter int              LOCK_CNT   = 2,
    parameter int              UNLOCK_CNT = 2
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            data_i,
    input  logic            realign_i,
    output logic [FROM-1:0] data_o,
    output logic            valid_o,
    output logic            sof_o,
    output logic            lock_o,
    output logic            sync_err_o
);

    localparam int WIDX_W = $clog2(FRAME_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [LOGFROM-1:0] c_BIT_LAST  = LOGFROM'(FROM - 1);
    localparam logic [WIDX_W-1:0]  c_WIDX_LAST = WIDX_W'(FRAME_LEN - 1);
    localparam logic [WIDX_W-1:0]  c_WIDX_ONE  = WIDX_W'(1);
    localparam logic [GOOD_W-1:0]  c_LOCK      = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  c_UNLOCK    = MISS_W'(UNLOCK_CNT);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [FROM-1:0]    r_sr;
    logic [LOGFROM-1:0] r_bitcnt;
    // r_widx is the frame slot of the word that will sit in r_sr at the next boundary
    logic [WIDX_W-1:0]  r_widx;
    logic [GOOD_W-1:0]  r_good;
    logic [MISS_W-1:0]  r_miss;
    logic [FROM-1:0]    r_data;
    logic               r_valid;
    logic               r_sof;
    logic               r_sync_err;

    logic               w_sync_hit;
    logic               w_boundary;
    logic               w_sync_slot;
    logic [GOOD_W-1:0]  w_good_nxt;
    logic [MISS_W-1:0]  w_miss_nxt;
    logic               w_lock;
    logic               w_emit_payload;
    logic               w_emit_err;

    assign w_sync_hit  = (r_sr == SYNC_WORD);
    assign w_boundary  = (r_bitcnt == c_BIT_LAST);
    assign w_sync_slot = (r_widx == '0);
    assign w_good_nxt  = r_good + GOOD_W'(1);
    assign w_miss_nxt  = r_miss + MISS_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            r_state <= c_ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (realign_i) begin
            w_state_nxt = c_ST_SEARCH;
        end else begin
            case (r_state)
                c_ST_SEARCH: begin
                    if (w_sync_hit) begin
                        w_state_nxt = (LOCK_CNT == 1) ? c_ST_LOCKED : c_ST_VERIFY;
                    end
                end
                c_ST_VERIFY: begin
                    if (w_boundary && w_sync_slot) begin
                        if (!w_sync_hit) begin
                            w_state_nxt = c_ST_SEARCH;
                        end else if (w_good_nxt >= c_LOCK) begin
                            w_state_nxt = c_ST_LOCKED;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    if (w_boundary && w_sync_slot && !w_sync_hit && (w_miss_nxt >= c_UNLOCK)) begin
                        w_state_nxt = c_ST_SEARCH;
                    end
                end
                default: w_state_nxt = c_ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        w_lock         = (r_state == c_ST_LOCKED);
        w_emit_payload = w_lock && w_boundary && !w_sync_slot && !realign_i;
        w_emit_err     = w_lock && w_boundary && w_sync_slot && !w_sync_hit && !realign_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            r_sr       <= '0;
            r_bitcnt   <= '0;
            r_widx     <= '0;
            r_good     <= '0;
            r_miss     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sr       <= {r_sr[FROM-2:0], data_i};
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_sync_err <= w_emit_err;
            if (w_emit_payload) begin
                r_data  <= r_sr;
                r_valid <= 1'b1;
                r_sof   <= (r_widx == c_WIDX_ONE);
            end
            if (realign_i) begin
                r_bitcnt <= '0;
                r_widx   <= '0;
                r_good   <= '0;
                r_miss   <= '0;
            end else if (r_state == c_ST_SEARCH) begin
                if (w_sync_hit) begin
                    r_bitcnt <= '0;
                    r_widx   <= c_WIDX_ONE;
                    r_good   <= GOOD_W'(1);
                    r_miss   <= '0;
                end
            end else begin
                r_bitcnt <= w_boundary ? '0 : r_bitcnt + LOGFROM'(1);
                if (w_boundary) begin
                    r_widx <= (r_widx == c_WIDX_LAST) ? '0 : r_widx + WIDX_W'(1);
                    if (w_sync_slot) begin
                        if (r_state == c_ST_VERIFY) begin
                            if (w_sync_hit && (r_good < c_LOCK)) begin
                                r_good <= w_good_nxt;
                            end
                            r_miss <= '0;
                        end else if (w_sync_hit) begin
                            r_miss <= '0;
                        end else if (r_miss < c_UNLOCK) begin
                            r_miss <= w_miss_nxt;
                        end
                    end
                end
            end
        end
    end

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign sof_o      = r_sof;
    assign lock_o     = w_lock;
    assign sync_err_o = r_sync_err;

endmodule
`default_nettype wire

// File: doc/tree_deserializer_aligner.md
Name: tree_deserializer_aligner

Overview:
- Receive-side counterpart of the tree serializer. Sits directly downstream of the serializer output register and consumes its 1-bit-per-clock stream.
- Shifts the stream into FROM-bit words and finds word/frame alignment from a periodic sync word using a SEARCH/VERIFY/LOCKED state machine.
- Emits aligned payload words with a valid strobe for loopback checking and link bring-up.

Parameters:
- FROM, 16, word width in bits; must match the serializer's FROM.
- LOGFROM, 4, clog2(FROM); sizes the bit counter.
- SYNC_WORD, 16'hF628, alignment word; must be non-zero.
- FRAME_LEN, 8, words per frame: 1 sync word plus FRAME_LEN-1 payload words; must be ≥2.
- LOCK_CNT, 2, consecutive correct sync words needed to lock, counting the first detection; must be ≥1.
- UNLOCK_CNT, 2, consecutive missed sync words in LOCKED that force SEARCH; must be ≥1.

Ports:
- clk_i  in  1  bit clock, same clock that drives the serializer output register.
- reset_ni  in  1  synchronous, active-high reset.
- data_i  in  1  serial bit stream; first bit of a word is its MSB.
- realign_i  in  1  one-cycle request to drop alignment and re-search.
- data_o  out  FROM  aligned payload word.
- valid_o  out  1  one-cycle strobe; data_o is valid.
- sof_o  out  1  asserted with valid_o on the first payload word of a frame.
- lock_o  out  1  high while in LOCKED.
- sync_err_o  out  1  one-cycle pulse on each missed sync word in LOCKED.

Behaviour:
- **Shift register.** sr[FROM-1:0] is updated every cycle as sr <= {sr[FROM-2:0], data_i}. The oldest bit therefore ends at the MSB.
- **Reset.** On reset_ni high at a rising edge:
  - state = SEARCH; sr, bit counter, word index (widx), good count and miss count all = 0.
  - data_o = 0, valid_o = 0, sof_o = 0, lock_o = 0, sync_err_o = 0.
  - Reset mid-frame discards the partial word; no strobe is generated.
- **Priority.** reset_ni > realign_i > normal operation.
- **realign_i.** Applies the same state and counter clearing as reset but leaves sr and data_o untouched. valid_o, sof_o, lock_o and sync_err_o are 0 from the next cycle.
- **Boundary cycle.** A cycle in which sr holds a complete aligned word.
  - The first boundary is the SEARCH match cycle.
  - Subsequent boundaries occur exactly FROM cycles apart.
  - widx is 0 at the match boundary and increments mod FRAME_LEN at each later boundary.
  - widx==0 marks a sync slot.
- **SEARCH.** Every cycle, compare sr with SYNC_WORD.
  - On match: restart the bit counter, set widx=0 and good=1.
  - If LOCK_CNT==1, go to LOCKED; otherwise go to VERIFY.
  - No outputs are generated in SEARCH.
- **VERIFY.** At sync-slot boundaries:
  - sr==SYNC_WORD: good++. When good reaches LOCK_CNT, go to LOCKED with miss=0.
  - Mismatch: go to SEARCH.
  - Payload slots are discarded (no valid_o).
- **LOCKED.** lock_o=1, registered, rising the cycle after the entering boundary.
  - Payload boundary (widx≠0): data_o<=sr and valid_o<=1 next cycle. sof_o<=1 when widx==1.
  - Sync-slot match: miss=0; no valid_o.
  - Sync-slot mismatch: sync_err_o pulses next cycle and miss++.
  - If miss reaches UNLOCK_CNT, go to SEARCH and lock_o falls next cycle. Otherwise stay LOCKED and keep outputting that frame's payload.
- **Latency.** Last bit of a word sampled at edge k → valid_o/data_o visible after edge k+1.
- **Strobe spacing.** valid_o is single-cycle and asserts at most once per FROM cycles.
- **Persistence.** data_o holds its last value between strobes.
- **Counter wrap.** The bit counter and widx wrap without any gap cycle. The good and miss counts saturate at their thresholds.

Test Plan:
1. **Basic lock.**
   - Stimulus: reset; 5 random bits; then frames [F628, 0001..0007] repeated.
   - Response: lock_o rises 1 cycle after the 2nd sync boundary. Next strobes are data_o=0001 (sof_o=1), 0002..0007 (sof_o=0), spaced 16 cycles. valid_o never asserts before lock.
2. **Single sync miss.**
   - Stimulus: while locked, one frame's sync is replaced by 0000.
   - Response: one sync_err_o pulse; lock_o stays 1; that frame's payload 0001..0007 is still output.
3. **Unlock and reacquire.**
   - Stimulus: two consecutive corrupted syncs.
   - Response: two sync_err_o pulses; lock_o falls after the 2nd; no valid_o until relock two good frames later.
4. **False sync in payload.**
   - Stimulus: during SEARCH, a payload word equals F628 at a misaligned position.
   - Response: enters VERIFY; the next sync-slot compare fails and returns to SEARCH; then locks on the true alignment with correct payload.
5. **realign_i mid-frame.**
   - Stimulus: realign_i pulsed at widx=3 while locked.
   - Response: lock_o=0 and valid_o=0 from the next cycle; relock after LOCK_CNT sync words.
6. **Reset mid-word.**
   - Stimulus: reset_ni high for 1 cycle mid-word while locked.
   - Response: all outputs 0 after that edge; no strobe for the partial word; clean relock afterwards.
